lsu: RTL and testbench

- Load/store unit between the MEM pipeline stage and `dmem`. It drives the `dmem` port set: `we`, `addr`, `wdata`, `wstrb`, and consumes combinational `rdata`.
- Aligns store data onto byte lanes and generates byte strobes.
- Extracts and extends load data.
- Splits word-crossing misaligned accesses into two aligned `dmem` accesses, stalling the pipeline via `o_busy`.

---
 rtl/lsu_if.sv | 32 +++
 rtl/lsu.sv | 173 +++++++++++++++++
 tb/tb_lsu.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Pipeline/dmem bundle for the load/store unit.
// The slave side is the LSU; the master side is the MEM stage plus dmem.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [XLEN-1:0]   i_addr;
  logic [XLEN-1:0]   i_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_fault;
  logic [XLEN-1:0]   o_rdata;
  logic              o_mem_we;
  logic [XLEN-1:0]   o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  logic [XLEN/8-1:0] o_mem_wstrb;
  logic [XLEN-1:0]   i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_busy, o_done, o_fault, o_rdata,
    output o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_busy, o_done, o_fault, o_rdata,
    input  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: lane alignment, strobes, load extension, and two-beat
// splitting of word-crossing accesses with a one-cycle stall.
module lsu #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic  i_clk,
  input logic  i_rst,
  lsu_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [XLEN-1:0]   buf_r;
  logic              latch_s;

  logic [1:0]        off_s;
  logic [3:0]        mask_s;
  logic [7:0]        m8_s;
  logic              legal_s;
  logic              crossing_s;
  logic              fault_s;
  logic [4:0]        lo_sh_s;
  logic [5:0]        hi_sh_s;
  logic [XLEN-1:0]   base_s;
  logic [XLEN-1:0]   next_s;
  logic [XLEN-1:0]   wdata_lo_s;
  logic [XLEN-1:0]   wdata_hi_s;
  logic [XLEN-1:0]   rd_lo_s;
  logic [XLEN-1:0]   rd_hi_s;
  logic [XLEN-1:0]   ext_lo_s;
  logic [XLEN-1:0]   ext_hi_s;

  logic              busy_s;
  logic              done_s;
  logic              flt_s;
  logic [XLEN-1:0]   rdata_s;
  logic              mem_we_s;
  logic [XLEN-1:0]   mem_addr_s;
  logic [XLEN-1:0]   mem_wdata_s;
  logic [XLEN/8-1:0] mem_wstrb_s;

  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] res;
    case (f3)
      3'd0:    res = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'd1:    res = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'd2:    res = raw;
      3'd4:    res = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'd5:    res = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Decode width, legality and whether the access straddles a word boundary
  always_comb begin
    off_s   = bus.i_addr[1:0];
    mask_s  = 4'b0000;
    legal_s = 1'b0;
    case (bus.i_funct3)
      3'd0: begin mask_s = 4'b0001; legal_s = 1'b1;       end
      3'd1: begin mask_s = 4'b0011; legal_s = 1'b1;       end
      3'd2: begin mask_s = 4'b1111; legal_s = 1'b1;       end
      3'd4: begin mask_s = 4'b0001; legal_s = !bus.i_we;  end
      3'd5: begin mask_s = 4'b0011; legal_s = !bus.i_we;  end
      default: begin mask_s = 4'b0000; legal_s = 1'b0;    end
    endcase
    m8_s       = {4'b0000, mask_s} << off_s;
    crossing_s = (m8_s[7:4] != 4'b0000);
    fault_s    = !legal_s || (crossing_s && !ALLOW_MISALIGNED);
  end

  // Lane shifting for both beats; the upper beat takes bytes shifted out of the lower one
  always_comb begin
    lo_sh_s    = {off_s, 3'b000};
    hi_sh_s    = 6'd32 - {1'b0, off_s, 3'b000};
    base_s     = {bus.i_addr[XLEN-1:2], 2'b00};
    next_s     = base_s + {{(XLEN-3){1'b0}}, 3'd4};
    wdata_lo_s = bus.i_wdata << lo_sh_s;
    wdata_hi_s = bus.i_wdata >> hi_sh_s;
    rd_lo_s    = bus.i_mem_rdata >> lo_sh_s;
    rd_hi_s    = (bus.i_mem_rdata << hi_sh_s) | (buf_r >> lo_sh_s);
    ext_lo_s   = extend_load(bus.i_funct3, rd_lo_s);
    ext_hi_s   = extend_load(bus.i_funct3, rd_hi_s);
  end

  // Next-state and dmem/pipeline outputs
  always_comb begin
    state_s     = state_r;
    latch_s     = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    flt_s       = 1'b0;
    rdata_s     = {XLEN{1'b0}};
    mem_we_s    = 1'b0;
    mem_addr_s  = base_s;
    mem_wdata_s = {XLEN{1'b0}};
    mem_wstrb_s = 4'b0000;
    case (state_r)
      IDLE: begin
        if (!bus.i_req) begin
          state_s = IDLE;
        end else if (fault_s) begin
          done_s = 1'b1;
          flt_s  = 1'b1;
        end else if (crossing_s) begin
          mem_we_s    = bus.i_we;
          mem_wstrb_s = m8_s[3:0];
          mem_wdata_s = wdata_lo_s;
          busy_s      = 1'b1;
          latch_s     = 1'b1;
          state_s     = SECOND;
        end else begin
          mem_we_s    = bus.i_we;
          mem_wstrb_s = m8_s[3:0];
          mem_wdata_s = wdata_lo_s;
          done_s      = 1'b1;
          rdata_s     = bus.i_we ? {XLEN{1'b0}} : ext_lo_s;
        end
      end
      SECOND: begin
        // Always fall back to IDLE, even if the requester broke the hold rule
        state_s    = IDLE;
        mem_addr_s = next_s;
        if (bus.i_req) begin
          mem_we_s    = bus.i_we;
          mem_wstrb_s = m8_s[7:4];
          mem_wdata_s = wdata_hi_s;
          done_s      = 1'b1;
          rdata_s     = bus.i_we ? {XLEN{1'b0}} : ext_hi_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and first-beat read buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      buf_r   <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        buf_r <= bus.i_mem_rdata;
      end else begin
        buf_r <= buf_r;
      end
    end
  end

  // Reset forces every output quiet, which also cancels a pending second beat
  assign bus.o_busy      = i_rst ? 1'b0 : busy_s;
  assign bus.o_done      = i_rst ? 1'b0 : done_s;
  assign bus.o_fault     = i_rst ? 1'b0 : flt_s;
  assign bus.o_rdata     = i_rst ? {XLEN{1'b0}} : rdata_s;
  assign bus.o_mem_we    = i_rst ? 1'b0 : mem_we_s;
  assign bus.o_mem_addr  = i_rst ? {XLEN{1'b0}} : mem_addr_s;
  assign bus.o_mem_wdata = i_rst ? {XLEN{1'b0}} : mem_wdata_s;
  assign bus.o_mem_wstrb = i_rst ? 4'b0000 : mem_wstrb_s;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table through a scoreboard, plus
// hand-written split, reset-abort and no-misalign sequences.
module tb_lsu;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  lsu_if lif ();
  lsu_if lif0 ();

  lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut  (.i_clk(i_clk), .i_rst(i_rst), .bus(lif.slave));
  lsu #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut0 (.i_clk(i_clk), .i_rst(i_rst), .bus(lif0.slave));

  // Behavioural dmem: 16 words, combinational read, byte-strobed write
  logic [31:0] mem [16];
  logic        clr = 1'b0;
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'h0;

  assign lif.i_mem_rdata  = mem[lif.o_mem_addr[5:2]];
  assign lif0.i_mem_rdata = 32'h0;

  always @(posedge i_clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (lif.o_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (lif.o_mem_wstrb[b]) mem[lif.o_mem_addr[5:2]][8*b +: 8] <= lif.o_mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[25];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    @(posedge i_clk); #1;
    clr = 1'b0;
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge i_clk); #1;
    poke_en = 1'b0;
  endtask

  // Entered and left at posedge+1; leaves i_req low so calls run back to back
  task automatic run_op(input vec_t v, input string nm);
    exp_t e;
    int   lat;
    bit   seen;
    e.is_load = !v.we; e.rdata = v.exp_rdata; e.fault = v.exp_fault; e.lat = v.exp_lat;
    sbq.push_back(e);
    lif.i_req = 1'b1; lif.i_we = v.we; lif.i_funct3 = v.f3;
    lif.i_addr = v.addr; lif.i_wdata = v.wdata;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 4) begin
      @(negedge i_clk);
      lat++;
      if (lif.o_done) begin
        seen = 1'b1;
        e = sbq.pop_front();
        chk({nm, " fault"}, {31'h0, lif.o_fault}, {31'h0, e.fault});
        chk({nm, " busy at done"}, {31'h0, lif.o_busy}, 32'h0);
        chk({nm, " latency"}, 32'(lat), 32'(e.lat));
        if (e.fault) begin
          chk({nm, " fault mem_we"}, {31'h0, lif.o_mem_we}, 32'h0);
          chk({nm, " fault wstrb"}, {28'h0, lif.o_mem_wstrb}, 32'h0);
          chk({nm, " fault rdata"}, lif.o_rdata, 32'h0);
        end else if (e.is_load) begin
          chk({nm, " rdata"}, lif.o_rdata, e.rdata);
        end
      end else begin
        chk({nm, " busy pending"}, {31'h0, lif.o_busy}, 32'h1);
      end
      @(posedge i_clk); #1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles, expected %0d", nm, lat, e.lat);
      void'(sbq.pop_front());
    end
    lif.i_req = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] er,
                              input logic ef, input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1'b1, 3'd2, 32'h0,        32'h11223344, 32'h0,        1'b0, 1);
    vecs[1]  = mk(1'b0, 3'd2, 32'h0,        32'h0,        32'h11223344, 1'b0, 1);
    vecs[2]  = mk(1'b1, 3'd2, 32'h4,        32'h88000000, 32'h0,        1'b0, 1);
    vecs[3]  = mk(1'b0, 3'd0, 32'h7,        32'h0,        32'hFFFFFF88, 1'b0, 1);
    vecs[4]  = mk(1'b0, 3'd4, 32'h7,        32'h0,        32'h00000088, 1'b0, 1);
    vecs[5]  = mk(1'b0, 3'd1, 32'h6,        32'h0,        32'hFFFF8800, 1'b0, 1);
    vecs[6]  = mk(1'b1, 3'd1, 32'h6,        32'h1234BEEF, 32'h0,        1'b0, 1);
    vecs[7]  = mk(1'b0, 3'd5, 32'h6,        32'h0,        32'h0000BEEF, 1'b0, 1);
    vecs[8]  = mk(1'b0, 3'd1, 32'h5,        32'h0,        32'hFFFFEF00, 1'b0, 1);
    vecs[9]  = mk(1'b0, 3'd0, 32'h0,        32'h0,        32'h00000044, 1'b0, 1);
    vecs[10] = mk(1'b0, 3'd5, 32'h2,        32'h0,        32'h00001122, 1'b0, 1);
    vecs[11] = mk(1'b0, 3'd3, 32'h0,        32'h0,        32'h0,        1'b1, 1);
    vecs[12] = mk(1'b1, 3'd4, 32'h0,        32'h000000FF, 32'h0,        1'b1, 1);
    vecs[13] = mk(1'b0, 3'd7, 32'h0,        32'h0,        32'h0,        1'b1, 1);
    vecs[14] = mk(1'b1, 3'd5, 32'h0,        32'h0000FFFF, 32'h0,        1'b1, 1);
    vecs[15] = mk(1'b0, 3'd2, 32'h0,        32'h0,        32'h11223344, 1'b0, 1);
    vecs[16] = mk(1'b0, 3'd1, 32'h3,        32'h0,        32'h00000011, 1'b0, 2);
    vecs[17] = mk(1'b1, 3'd2, 32'hFFFFFFFC, 32'h7F000000, 32'h0,        1'b0, 1);
    vecs[18] = mk(1'b0, 3'd5, 32'hFFFFFFFF, 32'h0,        32'h0000447F, 1'b0, 2);
    vecs[19] = mk(1'b0, 3'd4, 32'h1,        32'h0,        32'h00000033, 1'b0, 1);
    vecs[20] = mk(1'b1, 3'd0, 32'h1,        32'h000000A5, 32'h0,        1'b0, 1);
    vecs[21] = mk(1'b0, 3'd2, 32'h1,        32'h0,        32'h001122A5, 1'b0, 2);
    vecs[22] = mk(1'b1, 3'd1, 32'h7,        32'h0000CAFE, 32'h0,        1'b0, 2);
    vecs[23] = mk(1'b0, 3'd5, 32'h7,        32'h0,        32'h0000CAFE, 1'b0, 2);
    vecs[24] = mk(1'b0, 3'd2, 32'h6,        32'h0,        32'h00CAFEEF, 1'b0, 2);

    lif.i_req = 1'b1; lif.i_we = 1'b1; lif.i_funct3 = 3'd2;
    lif.i_addr = 32'h3; lif.i_wdata = 32'hAABBCCDD;
    lif0.i_req = 1'b0; lif0.i_we = 1'b0; lif0.i_funct3 = 3'd2;
    lif0.i_addr = 32'h0; lif0.i_wdata = 32'h0;
    clr = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset busy",  {31'h0, lif.o_busy},  32'h0);
    chk("reset done",  {31'h0, lif.o_done},  32'h0);
    chk("reset fault", {31'h0, lif.o_fault}, 32'h0);
    chk("reset mem_we", {31'h0, lif.o_mem_we}, 32'h0);
    chk("reset wstrb", {28'h0, lif.o_mem_wstrb}, 32'h0);
    chk("reset addr",  lif.o_mem_addr, 32'h0);
    chk("reset wdata", lif.o_mem_wdata, 32'h0);
    chk("reset rdata", lif.o_rdata, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; clr = 1'b0; lif.i_req = 1'b0;
    @(negedge i_clk);
    chk("idle done", {31'h0, lif.o_done}, 32'h0);
    chk("idle mem_we", {31'h0, lif.o_mem_we}, 32'h0);
    chk("idle wstrb", {28'h0, lif.o_mem_wstrb}, 32'h0);
    @(posedge i_clk); #1;

    // First store checked beat by beat, then the table runs back to back
    lif.i_req = 1'b1; lif.i_we = 1'b1; lif.i_funct3 = 3'd1;
    lif.i_addr = 32'h6; lif.i_wdata = 32'h0000BEEF;
    @(negedge i_clk);
    chk("sh addr",  lif.o_mem_addr, 32'h4);
    chk("sh wstrb", {28'h0, lif.o_mem_wstrb}, 32'hC);
    chk("sh wdata", lif.o_mem_wdata, 32'hBEEF0000);
    chk("sh done",  {31'h0, lif.o_done}, 32'h1);
    @(posedge i_clk); #1;
    lif.i_req = 1'b0;
    clear_mem();

    for (int i = 0; i < 25; i++) run_op(vecs[i], $sformatf("vec%0d", i));
    chk("fault left mem", mem[0], 32'h1122A544);
    chk("split sh lo", mem[1], 32'hFEEF0000);
    chk("split sh hi", mem[2], 32'h000000CA);

    // Split store beat by beat
    clear_mem();
    lif.i_req = 1'b1; lif.i_we = 1'b1; lif.i_funct3 = 3'd2;
    lif.i_addr = 32'h3; lif.i_wdata = 32'hAABBCCDD;
    @(negedge i_clk);
    chk("split0 addr",  lif.o_mem_addr, 32'h0);
    chk("split0 wstrb", {28'h0, lif.o_mem_wstrb}, 32'h8);
    chk("split0 wdata", lif.o_mem_wdata, 32'hDD000000);
    chk("split0 busy",  {31'h0, lif.o_busy}, 32'h1);
    chk("split0 done",  {31'h0, lif.o_done}, 32'h0);
    chk("split0 we",    {31'h0, lif.o_mem_we}, 32'h1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("split1 addr",  lif.o_mem_addr, 32'h4);
    chk("split1 wstrb", {28'h0, lif.o_mem_wstrb}, 32'h7);
    chk("split1 wdata", lif.o_mem_wdata, 32'h00AABBCC);
    chk("split1 busy",  {31'h0, lif.o_busy}, 32'h0);
    chk("split1 done",  {31'h0, lif.o_done}, 32'h1);
    @(posedge i_clk); #1;
    lif.i_req = 1'b0;
    run_op(mk(1'b0, 3'd2, 32'h3, 32'h0, 32'hAABBCCDD, 1'b0, 2), "lw split");
    run_op(mk(1'b0, 3'd2, 32'h0, 32'h0, 32'hDD000000, 1'b0, 1), "lw word0");

    // Reset during the second beat of a split store
    clear_mem();
    poke(4'd1, 32'hA5A5A5A5);
    lif.i_req = 1'b1; lif.i_we = 1'b1; lif.i_funct3 = 3'd2;
    lif.i_addr = 32'h2; lif.i_wdata = 32'h12345678;
    @(negedge i_clk);
    chk("abort beat0 busy",  {31'h0, lif.o_busy}, 32'h1);
    chk("abort beat0 wstrb", {28'h0, lif.o_mem_wstrb}, 32'hC);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("abort busy",   {31'h0, lif.o_busy}, 32'h0);
    chk("abort done",   {31'h0, lif.o_done}, 32'h0);
    chk("abort mem_we", {31'h0, lif.o_mem_we}, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; lif.i_req = 1'b0;
    chk("abort first half", mem[0], 32'h56780000);
    chk("abort second untouched", mem[1], 32'hA5A5A5A5);
    run_op(mk(1'b0, 3'd2, 32'h0, 32'h0, 32'h56780000, 1'b0, 1), "post-abort lw");

    // Instance with misalignment disallowed
    lif0.i_req = 1'b1; lif0.i_we = 1'b0; lif0.i_funct3 = 3'd2; lif0.i_addr = 32'h2;
    @(negedge i_clk);
    chk("nomis lw2 done",  {31'h0, lif0.o_done},  32'h1);
    chk("nomis lw2 fault", {31'h0, lif0.o_fault}, 32'h1);
    chk("nomis lw2 we",    {31'h0, lif0.o_mem_we}, 32'h0);
    chk("nomis lw2 busy",  {31'h0, lif0.o_busy},  32'h0);
    @(posedge i_clk); #1;
    lif0.i_funct3 = 3'd1; lif0.i_addr = 32'h1;
    @(negedge i_clk);
    chk("nomis lh1 fault", {31'h0, lif0.o_fault}, 32'h0);
    chk("nomis lh1 done",  {31'h0, lif0.o_done},  32'h1);
    @(posedge i_clk); #1;
    lif0.i_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
